// File: rtl/dadda_pkg.sv
// Shared widths and types for the dadda multiplier family.
// Operand and product typedefs are reused by every wrapper around a dadda tree.
package dadda_pkg;

  localparam int OPW = 11;
  localparam int PW  = 2 * OPW;

  typedef logic [OPW-1:0] operand_t;
  typedef logic [PW-1:0]  product_t;

endpackage

// File: rtl/dadda11.sv
// Combinational 11x11 unsigned Dadda multiplier.
// Partial-product columns are reduced with full/half adders to two rows, then summed.
module dadda11
  import dadda_pkg::*;
(
  input  operand_t a,
  input  operand_t b,
  output product_t y
);

  // Widest column during reduction is 11 partial products plus incoming carries.
  localparam int MAXH       = 16;
  localparam int NUM_STAGES = 5;
  localparam int STAGE_HEIGHT [NUM_STAGES] = '{9, 6, 4, 3, 2};

  typedef logic [MAXH-1:0] col_t;

  function automatic logic bit_at(col_t v, int idx);
    col_t t;
    t = v >> idx;
    return t[0];
  endfunction

  function automatic col_t with_bit(col_t v, int idx, logic b_in);
    return v | (col_t'(b_in) << idx);
  endfunction

  function automatic product_t dadda_mul(operand_t op_a, operand_t op_b);
    col_t     cur   [PW];
    col_t     nxt   [PW];
    int       cur_n [PW];
    int       nxt_n [PW];
    int       h;
    int       src;
    logic     x0, x1, x2, sum, carry;
    product_t row0, row1;

    for (int c = 0; c < PW; c++) begin
      cur[c]   = '0;
      cur_n[c] = 0;
    end
    for (int i = 0; i < OPW; i++) begin
      for (int j = 0; j < OPW; j++) begin
        cur[i+j]   = with_bit(cur[i+j], cur_n[i+j], op_a[i] & op_b[j]);
        cur_n[i+j] = cur_n[i+j] + 1;
      end
    end

    for (int s = 0; s < NUM_STAGES; s++) begin
      for (int c = 0; c < PW; c++) begin
        nxt[c]   = '0;
        nxt_n[c] = 0;
      end
      for (int c = 0; c < PW; c++) begin
        // Height counts carries already pushed in from column c-1 this stage.
        src = 0;
        h   = cur_n[c] + nxt_n[c];
        for (int k = 0; k < MAXH; k++) begin
          if (h > STAGE_HEIGHT[s]) begin
            x0 = bit_at(cur[c], src);
            x1 = bit_at(cur[c], src + 1);
            if (h - STAGE_HEIGHT[s] >= 2) begin
              x2    = bit_at(cur[c], src + 2);
              sum   = x0 ^ x1 ^ x2;
              carry = (x0 & x1) | (x2 & (x0 ^ x1));
              src   = src + 3;
              h     = h - 2;
            end else begin
              sum   = x0 ^ x1;
              carry = x0 & x1;
              src   = src + 2;
              h     = h - 1;
            end
            nxt[c]   = with_bit(nxt[c], nxt_n[c], sum);
            nxt_n[c] = nxt_n[c] + 1;
            if (c + 1 < PW) begin
              nxt[c+1]   = with_bit(nxt[c+1], nxt_n[c+1], carry);
              nxt_n[c+1] = nxt_n[c+1] + 1;
            end
          end
        end
        for (int k = 0; k < MAXH; k++) begin
          if (k >= src && k < cur_n[c]) begin
            nxt[c]   = with_bit(nxt[c], nxt_n[c], bit_at(cur[c], k));
            nxt_n[c] = nxt_n[c] + 1;
          end
        end
      end
      cur   = nxt;
      cur_n = nxt_n;
    end

    for (int c = 0; c < PW; c++) begin
      row0[c] = cur[c][0];
      row1[c] = cur[c][1];
    end
    // The exact product is below 2**22, so dropping carries out of bit 21 is safe.
    return row0 + row1;
  endfunction

  assign y = dadda_mul(a, b);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin request arbiter: searches upward from last+1 with wrap.
// The pointer register lives in the caller; last_d is its next value.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_req,
  output logic [ID_W-1:0]    last_d
);

  always_comb begin
    int idx;
    // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    idx       = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last) + off) % NUM_REQ;
      if (!any_req && req[idx]) begin
        any_req     = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
    last_d = advance ? grant_idx : last;
  end

endmodule

// File: rtl/dadda11_scheduler.sv
// Time-shares one dadda11 multiplier among NUM_REQ requesters with round-robin grants
// and a two-stage operand/product pipeline feeding a single tagged response port.
module dadda11_scheduler
  import dadda_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*OPW-1:0] req_a,
  input  logic [NUM_REQ*OPW-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [PW-1:0]          rsp_y,
  output logic [ID_W-1:0]        rsp_id
);

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               any_req;
  logic [ID_W-1:0]    last_q, last_d;

  logic               s1_valid_q, s1_valid_d;
  operand_t           s1_a_q, s1_a_d;
  operand_t           s1_b_q, s1_b_d;
  logic [ID_W-1:0]    s1_id_q, s1_id_d;

  logic               s2_valid_q, s2_valid_d;
  product_t           s2_y_q, s2_y_d;
  logic [ID_W-1:0]    s2_id_q, s2_id_d;

  logic               s1_load, s2_load, req_fire;
  operand_t           sel_a, sel_b;
  product_t           mul_y;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .last      (last_q),
    .advance   (req_fire),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req),
    .last_d    (last_d)
  );

  dadda11 u_mul (
    .a (s1_a_q),
    .b (s1_b_q),
    .y (mul_y)
  );

  assign sel_a = req_a[int'(grant_idx)*OPW +: OPW];
  assign sel_b = req_b[int'(grant_idx)*OPW +: OPW];

  // Ready ripples back combinationally from rsp_ready through s2_load.
  assign s2_load   = s1_valid_q & (~s2_valid_q | rsp_ready);
  assign s1_load   = ~s1_valid_q | s2_load;
  assign req_fire  = s1_load & any_req & ~rst;
  assign req_ready = req_fire ? grant : '0;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_y_d     = s2_y_q;
    s2_id_d    = s2_id_q;

    if (s1_load) begin
      s1_valid_d = any_req;
      if (any_req) begin
        s1_a_d  = sel_a;
        s1_b_d  = sel_b;
        s1_id_d = grant_idx;
      end
    end

    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_y_d     = mul_y;
      s2_id_d    = s1_id_q;
    end else if (s2_valid_q && rsp_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // NOTE: operand/product registers are reset too, because rsp_y and rsp_id must read 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q     <= ID_W'(NUM_REQ - 1);
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_y_q     <= '0;
      s2_id_q    <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values, keeping the pipeline stages distinct.
      last_q     <= last_d;
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_y_q     <= s2_y_d;
      s2_id_q    <= s2_id_d;
    end
  end

  assign rsp_valid = s2_valid_q;
  assign rsp_y     = s2_y_q;
  assign rsp_id    = s2_id_q;

endmodule

// File: tb/tb_dadda11_scheduler.sv
// Self-checking bench for dadda11_scheduler: directed scenarios plus a randomized
// run against a queue-based reference model of acceptance order and products.
module tb_dadda11_scheduler;

  localparam int N    = 4;
  localparam int OPW  = 11;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*OPW-1:0] req_a;
  logic [N*OPW-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [21:0]      rsp_y;
  logic [1:0]       rsp_id;

  dadda11_scheduler #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: operations in flight in acceptance order, each with its age in edges.
  typedef struct {
    int id;
    int y;
    int age;
  } op_t;

  op_t  q[$];
  int   rr_last;
  int   push_count;
  int   dut_rsp_count;
  int   acc_idx;

  logic [N-1:0] exp_ready;
  logic         exp_rsp_valid;
  int           exp_y, exp_id;
  logic [N-1:0] smp_ready, smp_valid;
  logic         smp_rsp_valid;
  logic [21:0]  smp_y;
  logic [1:0]   smp_id;

  function automatic int model_grant(logic [N-1:0] v, int last);
    for (int off = 1; off <= N; off++) begin
      if (v[(last + off) % N]) return (last + off) % N;
    end
    return -1;
  endfunction

  // One clock: sample at the falling edge, derive expectations, then advance the model.
  task automatic tick();
    int g;
    int a_v, b_v;
    @(negedge clk);
    smp_ready     = req_ready;
    smp_valid     = req_valid;
    smp_rsp_valid = rsp_valid;
    smp_y         = rsp_y;
    smp_id        = rsp_id;
    g             = model_grant(req_valid, rr_last);
    exp_ready     = '0;
    a_v           = 0;
    b_v           = 0;
    if (!rst && g >= 0 && (q.size() < 2 || rsp_ready)) begin
      exp_ready[g] = 1'b1;
      a_v = int'(req_a[g*OPW +: OPW]);
      b_v = int'(req_b[g*OPW +: OPW]);
    end
    exp_rsp_valid = !rst && q.size() > 0 && q[0].age >= 1;
    exp_y         = (q.size() > 0) ? q[0].y : 0;
    exp_id        = (q.size() > 0) ? q[0].id : 0;
    @(posedge clk);
    acc_idx = -1;
    if (smp_rsp_valid && rsp_ready) dut_rsp_count++;
    if (exp_rsp_valid && rsp_ready) void'(q.pop_front());
    foreach (q[k]) q[k].age++;
    if (exp_ready != '0) begin
      q.push_back('{id: g, y: a_v * b_v, age: 0});
      rr_last = g;
      acc_idx = g;
      push_count++;
    end
    #1;
  endtask

  task automatic set_op(int i, int a, int b);
    req_valid[i]         = 1'b1;
    req_a[i*OPW +: OPW]  = OPW'(a);
    req_b[i*OPW +: OPW]  = OPW'(b);
  endtask

  // After a handshake, give that requester a fresh random operation (or let it go idle).
  task automatic refresh(bit keep);
    if (acc_idx >= 0) begin
      req_a[acc_idx*OPW +: OPW] = OPW'($urandom);
      req_b[acc_idx*OPW +: OPW] = OPW'($urandom);
      req_valid[acc_idx]        = keep ? 1'b1 : 1'(($urandom_range(0, 1)));
    end
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    req_valid = '0;
    q.delete();
    rr_last   = N - 1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    rsp_ready = 1'b1;
    req_a     = '1;
    req_b     = '1;
    req_valid = '1;
    q.delete();
    rr_last   = N - 1;
    repeat (3) begin
      tick();
      checks++;
      if (smp_ready !== '0) begin
        failures++; $display("FAIL reset_ready got %b exp 0000", smp_ready);
      end
      checks++;
      if (smp_rsp_valid !== 1'b0 || smp_y !== '0 || smp_id !== '0) begin
        failures++;
        $display("FAIL reset_rsp got valid=%b y=%0d id=%0d exp 0/0/0", smp_rsp_valid, smp_y, smp_id);
      end
    end
    req_valid = '0;
    rst       = 1'b0;
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    set_op(0, 987, 135);
    tick();
    checks++;
    if (smp_ready !== 4'b0001) begin
      failures++; $display("FAIL single_grant got %b exp 0001", smp_ready);
    end
    req_valid = '0;
    tick();
    checks++;
    if (smp_rsp_valid !== 1'b0) begin
      failures++; $display("FAIL single_early got rsp_valid=%b exp 0", smp_rsp_valid);
    end
    tick();
    checks++;
    if (smp_rsp_valid !== 1'b1 || smp_y !== 22'd133245 || smp_id !== 2'd0) begin
      failures++;
      $display("FAIL single_rsp got valid=%b y=%0d id=%0d exp 1/133245/0", smp_rsp_valid, smp_y, smp_id);
    end
    tick();
    checks++;
    if (smp_rsp_valid !== 1'b0) begin
      failures++; $display("FAIL single_drain got rsp_valid=%b exp 0", smp_rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    int           gseq [5] = '{0, 1, 2, 3, 0};
    int           yseq [5] = '{525051, 21, 4190209, 0, 525051};
    logic [N-1:0] e;
    apply_reset();
    rsp_ready = 1'b1;
    set_op(0, 771, 681);
    set_op(1, 7, 3);
    set_op(2, 2047, 2047);
    set_op(3, 0, 5);
    for (int t = 0; t < 7; t++) begin
      tick();
      if (t < 5) begin
        e = '0;
        e[gseq[t]] = 1'b1;
        checks++;
        if (smp_ready !== e) begin
          failures++; $display("FAIL b2b_grant t=%0d got %b exp %b", t, smp_ready, e);
        end
      end
      if (t == 4) req_valid = '0;
      if (t >= 2) begin
        checks++;
        if (smp_rsp_valid !== 1'b1 || smp_y !== 22'(yseq[t-2]) || smp_id !== 2'(gseq[t-2])) begin
          failures++;
          $display("FAIL b2b_rsp t=%0d got valid=%b y=%0d id=%0d exp 1/%0d/%0d",
                   t, smp_rsp_valid, smp_y, smp_id, yseq[t-2], gseq[t-2]);
        end
      end
    end
    tick();
  endtask

  task automatic test_stall();
    int fired;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_op(i, $urandom_range(0, 2047), $urandom_range(0, 2047));
    repeat (4) begin
      tick();
      refresh(1'b1);
    end
    rsp_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      checks++;
      if (smp_ready !== '0) begin
        failures++; $display("FAIL stall_ready t=%0d got %b exp 0000", t, smp_ready);
      end
      checks++;
      if (smp_rsp_valid !== 1'b1 || smp_y !== 22'(exp_y) || smp_id !== 2'(exp_id)) begin
        failures++;
        $display("FAIL stall_hold t=%0d got valid=%b y=%0d id=%0d exp 1/%0d/%0d",
                 t, smp_rsp_valid, smp_y, smp_id, exp_y, exp_id);
      end
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    fired     = 0;
    for (int t = 0; t < 5; t++) begin
      tick();
      if (smp_rsp_valid) begin
        fired++;
        checks++;
        if (smp_y !== 22'(exp_y) || smp_id !== 2'(exp_id)) begin
          failures++;
          $display("FAIL stall_resume t=%0d got y=%0d id=%0d exp %0d/%0d", t, smp_y, smp_id, exp_y, exp_id);
        end
      end
    end
    checks++;
    if (fired != 2) begin
      failures++; $display("FAIL stall_buffered got %0d responses exp 2", fired);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    rsp_ready = 1'b1;
    set_op(2, 100, 200);
    tick();
    checks++;
    if (smp_ready !== 4'b0100) begin
      failures++; $display("FAIL wrap_first got %b exp 0100", smp_ready);
    end
    refresh(1'b1);
    tick();
    checks++;
    if (smp_ready !== 4'b0100) begin
      failures++; $display("FAIL wrap_again got %b exp 0100", smp_ready);
    end
    refresh(1'b1);
    set_op(1, 33, 44);
    tick();
    checks++;
    if (smp_ready !== 4'b0010) begin
      failures++; $display("FAIL wrap_join1 got %b exp 0010", smp_ready);
    end
    refresh(1'b1);
    set_op(3, 5, 6);
    tick();
    checks++;
    if (smp_ready !== 4'b0100) begin
      failures++; $display("FAIL wrap_next2 got %b exp 0100", smp_ready);
    end
    req_valid = '0;
    repeat (4) begin
      tick();
      if (exp_rsp_valid) begin
        checks++;
        if (smp_rsp_valid !== 1'b1 || smp_y !== 22'(exp_y) || smp_id !== 2'(exp_id)) begin
          failures++;
          $display("FAIL wrap_rsp got valid=%b y=%0d id=%0d exp 1/%0d/%0d", smp_rsp_valid, smp_y, smp_id, exp_y, exp_id);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    rsp_ready = 1'b0;
    set_op(0, 11, 13);
    repeat (3) tick();
    checks++;
    if (smp_rsp_valid !== 1'b1) begin
      failures++; $display("FAIL midrst_full got rsp_valid=%b exp 1", smp_rsp_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_y !== '0 || req_ready !== '0) begin
      failures++;
      $display("FAIL midrst_async got valid=%b y=%0d ready=%b exp 0/0/0000", rsp_valid, rsp_y, req_ready);
    end
    q.delete();
    rr_last   = N - 1;
    req_valid = '0;
    tick();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    set_op(1, 25, 40);
    tick();
    checks++;
    if (smp_ready !== 4'b0010) begin
      failures++; $display("FAIL midrst_grant got %b exp 0010", smp_ready);
    end
    req_valid = '0;
    tick();
    tick();
    checks++;
    if (smp_rsp_valid !== 1'b1 || smp_y !== 22'd1000 || smp_id !== 2'd1) begin
      failures++;
      $display("FAIL midrst_rsp got valid=%b y=%0d id=%0d exp 1/1000/1", smp_rsp_valid, smp_y, smp_id);
    end
    tick();
  endtask

  task automatic test_random();
    int start_push, start_rsp, cycles;
    int wait_cnt [N];
    apply_reset();
    foreach (wait_cnt[i]) wait_cnt[i] = 0;
    start_push = push_count;
    start_rsp  = dut_rsp_count;
    cycles     = 0;
    while (push_count - start_push < 10000 && cycles < 40000) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          set_op(i, $urandom_range(0, 2047), $urandom_range(0, 2047));
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
      cycles++;
      checks++;
      if (smp_ready !== exp_ready) begin
        failures++; $display("FAIL rand_ready cyc=%0d got %b exp %b", cycles, smp_ready, exp_ready);
      end
      checks++;
      if (smp_rsp_valid !== exp_rsp_valid) begin
        failures++; $display("FAIL rand_rsp_valid cyc=%0d got %b exp %b", cycles, smp_rsp_valid, exp_rsp_valid);
      end
      if (exp_rsp_valid) begin
        checks++;
        if (smp_y !== 22'(exp_y) || smp_id !== 2'(exp_id)) begin
          failures++;
          $display("FAIL rand_rsp cyc=%0d got y=%0d id=%0d exp %0d/%0d", cycles, smp_y, smp_id, exp_y, exp_id);
        end
      end
      if (acc_idx >= 0) begin
        for (int i = 0; i < N; i++) begin
          if (i != acc_idx && smp_valid[i]) begin
            wait_cnt[i]++;
            checks++;
            if (wait_cnt[i] > N) begin
              failures++; $display("FAIL rand_fair req=%0d waited %0d grants exp <= %0d", i, wait_cnt[i], N);
            end
          end
        end
        wait_cnt[acc_idx] = 0;
      end
      refresh(1'b0);
    end
    checks++;
    if (push_count - start_push < 10000) begin
      failures++; $display("FAIL rand_budget got %0d ops exp 10000", push_count - start_push);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (5) tick();
    checks++;
    if (dut_rsp_count - start_rsp != push_count - start_push) begin
      failures++;
      $display("FAIL rand_count got %0d responses exp %0d", dut_rsp_count - start_rsp, push_count - start_push);
    end
  endtask

  initial begin
    rst           = 1'b1;
    req_valid     = '0;
    req_a         = '0;
    req_b         = '0;
    rsp_ready     = 1'b0;
    push_count    = 0;
    dut_rsp_count = 0;
    acc_idx       = -1;
    rr_last       = N - 1;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1);
  end

endmodule
